// File: rtl/keymgr_key_assemble_if.sv
// Word-serial key input, consumer clear, and the packed key output of keymgr_key_assemble.
// Handshake: a word transfers on a rising clk edge where word_valid_i && word_ready_o.
interface keymgr_key_assemble_if #(
  parameter int NumRegsKey   = 8,
  parameter int NumSharesKey = 2
);
  localparam int KeyW = NumSharesKey * NumRegsKey * 32;

  logic            word_valid_i;
  logic            word_ready_o;
  logic [31:0]     word_i;
  logic            word_last_i;
  logic            clear_i;
  logic            key_valid_o;
  logic [KeyW-1:0] key_o;
  logic            err_o;

  // Key manager word port and sideload consumer side.
  modport master (
    output word_valid_i, word_i, word_last_i, clear_i,
    input  word_ready_o, key_valid_o, key_o, err_o
  );

  // Assembler side.
  modport slave (
    input  word_valid_i, word_i, word_last_i, clear_i,
    output word_ready_o, key_valid_o, key_o, err_o
  );
endinterface

// File: rtl/keymgr_key_assemble.sv
// Assembles a word-serial hardware key into the packed two-share sideload key.
// Optional macro KEYMGR_KEY_ASSEMBLE_FRAMING_EN enables word_last_i framing checks and err_o.
module keymgr_key_assemble #(
  parameter int NumRegsKey   = 8,
  parameter int NumSharesKey = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  keymgr_key_assemble_if.slave bus,
  output logic [1:0]           dbg_state_o
);

  localparam int N    = NumSharesKey * NumRegsKey;
  localparam int KeyW = N * 32;
  localparam int CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VALID   = 2'd1,
    ST_WIPE    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [KeyW-1:0] key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            err_q, err_d;
  logic            word_ready;
  logic            cnt_last;
  logic            frame_err;

  assign cnt_last = (cnt_q == CntW'(N - 1));

`ifdef KEYMGR_KEY_ASSEMBLE_FRAMING_EN
  // last must coincide exactly with the final slot.
  assign frame_err = (bus.word_last_i != cnt_last);
`else
  logic unused_word_last;
  assign unused_word_last = bus.word_last_i;
  assign frame_err        = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    err_d       = 1'b0;
    word_ready  = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        // Clear wins over a coincident word: ready drops so nothing is accepted.
        word_ready = !bus.clear_i;
        if (bus.clear_i) begin
          state_d     = ST_WIPE;
          cnt_d       = '0;
          key_d       = '0;
          key_valid_d = 1'b0;
        end else if (bus.word_valid_i) begin
          if (frame_err) begin
            state_d     = ST_WIPE;
            cnt_d       = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
            err_d       = 1'b1;
          end else begin
            for (int s = 0; s < N; s++) begin
              if (cnt_q == CntW'(s)) key_d[s*32 +: 32] = bus.word_i;
            end
            if (cnt_last) begin
              state_d     = ST_VALID;
              cnt_d       = '0;
              key_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      ST_VALID: begin
        if (bus.clear_i) begin
          state_d     = ST_WIPE;
          cnt_d       = '0;
          key_d       = '0;
          key_valid_d = 1'b0;
        end
      end

      ST_WIPE: begin
        state_d = ST_COLLECT;
      end

      default: begin
        state_d     = ST_COLLECT;
        cnt_d       = '0;
        key_d       = '0;
        key_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.word_ready_o = word_ready;
  assign bus.key_valid_o  = key_valid_q;
  assign bus.key_o        = key_q;
  assign bus.err_o        = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_keymgr_key_assemble.sv
// Directed and randomized-gap bench for keymgr_key_assemble with a word scoreboard.
module tb_keymgr_key_assemble;

  localparam int NR = 8;
  localparam int NS = 2;
  localparam int N  = NR * NS;
  localparam int KW = N * 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   exp_q[$];
  logic [KW-1:0] last_key;

  keymgr_key_assemble_if #(.NumRegsKey(NR), .NumSharesKey(NS)) bus ();

  keymgr_key_assemble #(.NumRegsKey(NR), .NumSharesKey(NS)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one word and waits (bounded) for the handshake; returns at posedge+1.
  task automatic send_word(input logic [31:0] w, input logic last);
    int waited;
    waited = 0;
    bus.word_valid_i = 1'b1;
    bus.word_i       = w;
    bus.word_last_i  = last;
    @(negedge clk);
    while (!bus.word_ready_o && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("word_ready", KW'(bus.word_ready_o), KW'(1));
    if (bus.word_ready_o) exp_q.push_back(w);
    @(posedge clk); #1;
    bus.word_valid_i = 1'b0;
    bus.word_last_i  = 1'b0;
  endtask

  // Pops one full key from the scoreboard and compares it against key_o.
  task automatic compare_key(input string tag);
    logic [KW-1:0] exp_key;
    check({tag, "_sb_depth"}, KW'(exp_q.size()), KW'(N));
    exp_key = '0;
    for (int c = 0; c < N; c++) begin
      if (exp_q.size() > 0) exp_key[c*32 +: 32] = exp_q.pop_front();
    end
    last_key = exp_key;
    check(tag, bus.key_o, exp_key);
  endtask

  task automatic send_key(input string tag, input logic [31:0] base, input bit rnd, input bit gaps);
    int g;
    for (int c = 0; c < N; c++) begin
      g = gaps ? int'($urandom_range(0, 1)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      send_word(rnd ? $urandom : base + 32'(c), c == N - 1);
      if (c < N - 1) check({tag, "_no_early_valid"}, KW'(bus.key_valid_o), KW'(0));
    end
    check({tag, "_key_valid"}, KW'(bus.key_valid_o), KW'(1));
    check({tag, "_ready_in_valid"}, KW'(bus.word_ready_o), KW'(0));
    check({tag, "_state_valid"}, KW'(dbg_state), KW'(1));
    compare_key(tag);
  endtask

  task automatic clear_key(input string tag);
    bus.clear_i = 1'b1;
    @(posedge clk); #1;
    bus.clear_i = 1'b0;
    check({tag, "_wipe_valid"}, KW'(bus.key_valid_o), KW'(0));
    check({tag, "_wipe_key"}, bus.key_o, '0);
    check({tag, "_wipe_state"}, KW'(dbg_state), KW'(2));
    check({tag, "_wipe_ready"}, KW'(bus.word_ready_o), KW'(0));
    @(posedge clk); #1;
    check({tag, "_post_ready"}, KW'(bus.word_ready_o), KW'(1));
  endtask

  initial begin
    bus.word_valid_i = 1'b0;
    bus.word_i       = '0;
    bus.word_last_i  = 1'b0;
    bus.clear_i      = 1'b0;
    last_key         = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_key", bus.key_o, '0);
    check("rst_valid", KW'(bus.key_valid_o), KW'(0));
    check("rst_err", KW'(bus.err_o), KW'(0));
    check("rst_state", KW'(dbg_state), KW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", KW'(bus.word_ready_o), KW'(1));
    @(posedge clk); #1;

    // back-to-back key, then hold while word_valid is ignored
    send_key("key1", 32'h1000_0000, 1'b0, 1'b0);
    check("key1_s1w7", KW'(bus.key_o[511:480]), KW'(32'h1000_000F));
    bus.word_valid_i = 1'b1;
    bus.word_i       = 32'hFFFF_FFFF;
    repeat (3) begin @(posedge clk); #1; end
    bus.word_valid_i = 1'b0;
    check("hold_key", bus.key_o, last_key);
    check("hold_valid", KW'(bus.key_valid_o), KW'(1));
    clear_key("clr1");

    // clear coinciding with a word mid-collection
    for (int c = 0; c < 5; c++) send_word(32'h2000_0000 + 32'(c), 1'b0);
    bus.clear_i      = 1'b1;
    bus.word_valid_i = 1'b1;
    bus.word_i       = 32'hDEAD_BEEF;
    @(negedge clk);
    check("clr_vs_word_ready", KW'(bus.word_ready_o), KW'(0));
    @(posedge clk); #1;
    bus.clear_i      = 1'b0;
    bus.word_valid_i = 1'b0;
    check("clr_mid_key", bus.key_o, '0);
    check("clr_mid_state", KW'(dbg_state), KW'(2));
    exp_q.delete();
    send_key("key3", 32'h3000_0000, 1'b0, 1'b0);
    clear_key("clr3");

`ifdef KEYMGR_KEY_ASSEMBLE_FRAMING_EN
    // early last on word 3
    for (int c = 0; c < 3; c++) send_word(32'h4000_0000 + 32'(c), 1'b0);
    send_word(32'h4000_0003, 1'b1);
    check("frm_err_pulse", KW'(bus.err_o), KW'(1));
    check("frm_valid", KW'(bus.key_valid_o), KW'(0));
    check("frm_key", bus.key_o, '0);
    @(posedge clk); #1;
    check("frm_err_once", KW'(bus.err_o), KW'(0));
    check("frm_valid_after", KW'(bus.key_valid_o), KW'(0));
    exp_q.delete();
    send_key("key4", 32'h4100_0000, 1'b0, 1'b0);
    clear_key("clr4");
`else
    // without framing, a stray last is ignored and err_o stays low
    for (int c = 0; c < N; c++) begin
      send_word(32'h4000_0000 + 32'(c), (c == 3) || (c == N - 1));
      check("nofrm_err", KW'(bus.err_o), KW'(0));
    end
    check("nofrm_valid", KW'(bus.key_valid_o), KW'(1));
    compare_key("key4");
    clear_key("clr4");
`endif

    // asynchronous reset mid-collection
    for (int c = 0; c < 10; c++) send_word(32'h5000_0000 + 32'(c), 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_key", bus.key_o, '0);
    check("arst_valid", KW'(bus.key_valid_o), KW'(0));
    check("arst_err", KW'(bus.err_o), KW'(0));
    check("arst_state", KW'(dbg_state), KW'(0));
    #2 rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    send_key("key6", 32'h6000_0000, 1'b0, 1'b0);
    clear_key("clr6");

    // random data with random valid gaps
    send_key("rnd1", 32'h0, 1'b1, 1'b1);
    clear_key("clr_rnd1");
    send_key("rnd2", 32'h0, 1'b1, 1'b1);
    clear_key("clr_rnd2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
